// File: rtl/imem_port_arbiter.sv
// Instruction-memory port arbiter: shares one synchronous-read RAM port
// between pipeline fetch and the debug program loader.
module imem_port_arbiter #(
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_inst,
    output logic              fetch_valid,
    output logic              fetch_stall,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ack,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_rvalid,
    output logic [CNT_W-1:0]  load_count,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_FETCH,
        OWN_LDREAD
    } owner_e;

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0]    BURST_MAX = BW'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [BW-1:0]     burst_q, burst_d;
    owner_e            owner_q, owner_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ld_gnt;
    logic              f_gnt;

    // Grants are forced off while reset is held so every output reads 0.
    always_comb begin
        ld_gnt = 1'b0;
        f_gnt  = 1'b0;
        if (!reset) begin
            ld_gnt = ld_req & (~fetch_req | (burst_q < BURST_MAX));
            f_gnt  = fetch_req & ~ld_gnt;
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (ld_gnt) begin
            mem_addr  = ld_addr;
            mem_we    = ld_we;
            mem_wdata = ld_wdata;
        end else if (f_gnt) begin
            mem_addr  = fetch_addr;
        end
    end

    assign ld_ack      = ld_gnt;
    assign fetch_stall = fetch_req & ~f_gnt & ~reset;

    assign fetch_valid = (owner_q == OWN_FETCH);
    assign ld_rvalid   = (owner_q == OWN_LDREAD);
    assign ld_rdata    = ld_rvalid ? mem_rdata : '0;
    assign fetch_inst  = fetch_valid ? mem_rdata : inst_q;
    assign load_count  = cnt_q;

    always_comb begin
        burst_d = '0;
        if (ld_gnt && fetch_req) begin
            burst_d = (burst_q == BURST_MAX) ? burst_q : burst_q + BW'(1);
        end

        owner_d = OWN_NONE;
        if (f_gnt) begin
            owner_d = OWN_FETCH;
        end else if (ld_gnt && !ld_we) begin
            owner_d = OWN_LDREAD;
        end

        // Held copy keeps fetch_inst stable across stalls.
        inst_d = fetch_valid ? mem_rdata : inst_q;

        cnt_d = cnt_q;
        if (ld_gnt && ld_we && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            burst_q <= '0;
            owner_q <= OWN_NONE;
            inst_q  <= '0;
            cnt_q   <= '0;
        end else begin
            burst_q <= burst_d;
            owner_q <= owner_d;
            inst_q  <= inst_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a behavioural 2048x32
// synchronous-read memory on the port.
module tb_imem_port_arbiter;

    localparam logic [31:0] M0 = 32'h0001_1821;
    localparam logic [31:0] M1 = 32'h0010_0093;
    localparam logic [31:0] M2 = 32'h0020_8113;
    localparam logic [31:0] M3 = 32'h0031_01B3;
    localparam logic [31:0] M7 = 32'h0BAD_F00D;
    localparam logic [31:0] DB = 32'hDEAD_BEEF;
    localparam logic [31:0] W0 = 32'h1234_5678;

    logic        clock = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [10:0] fetch_addr;
    logic [31:0] fetch_inst;
    logic        fetch_valid;
    logic        fetch_stall;
    logic        ld_req;
    logic        ld_we;
    logic [10:0] ld_addr;
    logic [31:0] ld_wdata;
    logic        ld_ack;
    logic [31:0] ld_rdata;
    logic        ld_rvalid;
    logic [11:0] load_count;
    logic [10:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:2047];

    int n_cmp = 0;
    int n_bad = 0;

    imem_port_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_inst (fetch_inst),
        .fetch_valid(fetch_valid),
        .fetch_stall(fetch_stall),
        .ld_req     (ld_req),
        .ld_we      (ld_we),
        .ld_addr    (ld_addr),
        .ld_wdata   (ld_wdata),
        .ld_ack     (ld_ack),
        .ld_rdata   (ld_rdata),
        .ld_rvalid  (ld_rvalid),
        .load_count (load_count),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    typedef struct {
        logic        fr;
        logic [10:0] fa;
        logic        lr;
        logic        lw;
        logic [10:0] la;
        logic [31:0] lwd;
        logic        e_ack;
        logic        e_st;
        logic        e_we;
        logic [10:0] e_ma;
        logic [31:0] e_wd;
        logic        e_fv;
        logic [31:0] e_fi;
        logic        e_rv;
        logic [31:0] e_rd;
        logic [11:0] e_lc;
    } vec_t;

    function automatic vec_t mk(
        input int fr, input int fa, input int lr, input int lw,
        input int la, input logic [31:0] lwd,
        input int ack, input int st, input int we, input int ma,
        input logic [31:0] wd, input int fv, input logic [31:0] fi,
        input int rv, input logic [31:0] rd, input int lc);
        vec_t v;
        v.fr = fr[0];    v.fa = 11'(fa);
        v.lr = lr[0];    v.lw = lw[0];
        v.la = 11'(la);  v.lwd = lwd;
        v.e_ack = ack[0]; v.e_st = st[0];
        v.e_we = we[0];  v.e_ma = 11'(ma);
        v.e_wd = wd;     v.e_fv = fv[0];
        v.e_fi = fi;     v.e_rv = rv[0];
        v.e_rd = rd;     v.e_lc = 12'(lc);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic fr, input logic [10:0] fa,
                         input logic lr, input logic lw,
                         input logic [10:0] la, input logic [31:0] lwd);
        fetch_req = fr;  fetch_addr = fa;
        ld_req = lr;     ld_we = lw;
        ld_addr = la;    ld_wdata = lwd;
    endtask

    vec_t vecs [16];

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
        mem[0] = M0; mem[1] = M1; mem[2] = M2; mem[3] = M3; mem[7] = M7;

        //        fr fa lr lw la lwd  ack st we ma wd   fv fi  rv rd  lc
        vecs[0]  = mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  1, M0, 0, 0,  0);
        vecs[1]  = mk(1, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0,  1, M1, 0, 0,  0);
        vecs[2]  = mk(1, 2, 0, 0, 0, 0,  0, 0, 0, 2, 0,  1, M2, 0, 0,  0);
        vecs[3]  = mk(1, 3, 0, 0, 0, 0,  0, 0, 0, 3, 0,  1, M3, 0, 0,  0);
        vecs[4]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, M3, 0, 0,  0);
        vecs[5]  = mk(0, 0, 1, 1, 5, DB, 1, 0, 1, 5, DB, 0, M3, 0, 0,  1);
        vecs[6]  = mk(0, 0, 1, 0, 5, 0,  1, 0, 0, 5, 0,  0, M3, 1, DB, 1);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, M3, 0, 0,  1);
        vecs[8]  = mk(0, 0, 1, 1, 0, W0, 1, 0, 1, 0, W0, 0, M3, 0, 0,  2);
        vecs[9]  = mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  1, W0, 0, 0,  2);
        vecs[10] = mk(1, 1, 1, 0, 5, 0,  1, 1, 0, 5, 0,  0, W0, 1, DB, 2);
        vecs[11] = mk(1, 1, 1, 0, 5, 0,  1, 1, 0, 5, 0,  0, W0, 1, DB, 2);
        vecs[12] = mk(1, 1, 1, 0, 5, 0,  1, 1, 0, 5, 0,  0, W0, 1, DB, 2);
        vecs[13] = mk(1, 1, 1, 0, 5, 0,  1, 1, 0, 5, 0,  0, W0, 1, DB, 2);
        vecs[14] = mk(1, 1, 1, 0, 5, 0,  0, 0, 0, 1, 0,  1, M1, 0, 0,  2);
        vecs[15] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, M1, 0, 0,  2);

        reset = 1'b1;
        drive(1'b0, 11'd0, 1'b0, 1'b0, 11'd0, 32'h0);
        repeat (2) @(posedge clock);
        #1;
        chk("rst fetch_inst", fetch_inst, 32'h0);
        chk("rst fetch_valid", 32'(fetch_valid), 32'h0);
        chk("rst fetch_stall", 32'(fetch_stall), 32'h0);
        chk("rst ld_ack", 32'(ld_ack), 32'h0);
        chk("rst ld_rdata", ld_rdata, 32'h0);
        chk("rst ld_rvalid", 32'(ld_rvalid), 32'h0);
        chk("rst load_count", 32'(load_count), 32'h0);
        chk("rst mem_addr", 32'(mem_addr), 32'h0);
        chk("rst mem_we", 32'(mem_we), 32'h0);
        chk("rst mem_wdata", mem_wdata, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            drive(vecs[i].fr, vecs[i].fa, vecs[i].lr, vecs[i].lw,
                  vecs[i].la, vecs[i].lwd);
            #1;
            chk($sformatf("v%0d ld_ack", i), 32'(ld_ack), 32'(vecs[i].e_ack));
            chk($sformatf("v%0d stall", i), 32'(fetch_stall), 32'(vecs[i].e_st));
            chk($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(vecs[i].e_we));
            chk($sformatf("v%0d mem_addr", i), 32'(mem_addr), 32'(vecs[i].e_ma));
            chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_wd);
            @(posedge clock);
            #1;
            chk($sformatf("v%0d fetch_valid", i), 32'(fetch_valid), 32'(vecs[i].e_fv));
            chk($sformatf("v%0d fetch_inst", i), fetch_inst, vecs[i].e_fi);
            chk($sformatf("v%0d ld_rvalid", i), 32'(ld_rvalid), 32'(vecs[i].e_rv));
            chk($sformatf("v%0d ld_rdata", i), ld_rdata, vecs[i].e_rd);
            chk($sformatf("v%0d load_count", i), 32'(load_count), 32'(vecs[i].e_lc));
        end

        // Sustained contention: loader reads addr 7, fetch wants addr 2.
        begin
            logic [31:0] exp_inst;
            logic        is_f;
            exp_inst = M1;
            for (int c = 0; c < 10; c++) begin
                is_f = (c == 4) || (c == 9);
                @(negedge clock);
                drive(1'b1, 11'd2, 1'b1, 1'b0, 11'd7, 32'h0);
                #1;
                chk($sformatf("cont%0d ld_ack", c), 32'(ld_ack), 32'(!is_f));
                chk($sformatf("cont%0d stall", c), 32'(fetch_stall), 32'(!is_f));
                @(posedge clock);
                #1;
                if (is_f) exp_inst = M2;
                chk($sformatf("cont%0d fetch_valid", c), 32'(fetch_valid), 32'(is_f));
                chk($sformatf("cont%0d fetch_inst", c), fetch_inst, exp_inst);
                chk($sformatf("cont%0d ld_rvalid", c), 32'(ld_rvalid), 32'(!is_f));
                chk($sformatf("cont%0d ld_rdata", c), ld_rdata, is_f ? 32'h0 : M7);
            end
        end

        // Reset while the fourth loader read of a burst is in flight.
        @(negedge clock);
        drive(1'b0, 11'd0, 1'b0, 1'b0, 11'd0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            drive(1'b1, 11'd2, 1'b1, 1'b0, 11'd7, 32'h0);
            #1;
            chk($sformatf("pre%0d ld_ack", c), 32'(ld_ack), 32'h1);
        end
        @(negedge clock);
        #1;
        chk("rst4 ld_ack", 32'(ld_ack), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst4 load_count", 32'(load_count), 32'h0);
        @(posedge clock);
        #1;
        chk("rst4 ld_rvalid", 32'(ld_rvalid), 32'h0);
        chk("rst4 fetch_valid", 32'(fetch_valid), 32'h0);
        chk("rst4 ld_rdata", ld_rdata, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clock);
            #1;
            chk($sformatf("post%0d ld_ack", c), 32'(ld_ack), 32'(c != 4));
            @(posedge clock);
            #1;
            chk($sformatf("post%0d ld_rvalid", c), 32'(ld_rvalid), 32'(c != 4));
            chk($sformatf("post%0d fetch_valid", c), 32'(fetch_valid), 32'(c == 4));
        end
        chk("post fetch_inst", fetch_inst, M2);
        chk("post load_count", 32'(load_count), 32'h0);

        @(negedge clock);
        drive(1'b0, 11'd0, 1'b0, 1'b0, 11'd0, 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares the single-port, synchronous-read instruction memory (2048 x 32) between the pipeline fetch stage and the debug program loader.
- The loader writes program words into memory and reads them back.
- The arbiter grants one requester per cycle, routes the 1-cycle-latency read data back to its owner, and stalls fetch while the loader holds the port.
- A burst limit stops the loader from starving fetch.

Parameters:
- ADDR_W, 11: memory word-address width (2048 words).
- DATA_W, 32: instruction width.
- MAX_BURST, 4: maximum consecutive loader grants while fetch_req is high; the next eligible cycle goes to fetch.
- CNT_W, 12: width of load_count.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- fetch_req  in  1  fetch stage requests a read this cycle.
- fetch_addr  in  ADDR_W  fetch word address.
- fetch_inst  out  DATA_W  fetched instruction; holds the last fetched value.
- fetch_valid  out  1  fetch_inst is new this cycle.
- fetch_stall  out  1  fetch_req was not granted this cycle.
- ld_req  in  1  loader requests an access.
- ld_we  in  1  1 = write, 0 = read.
- ld_addr  in  ADDR_W  loader word address.
- ld_wdata  in  DATA_W  loader write data.
- ld_ack  out  1  loader access granted this cycle.
- ld_rdata  out  DATA_W  loader read data.
- ld_rvalid  out  1  ld_rdata valid this cycle.
- load_count  out  CNT_W  granted loader writes since reset.
- mem_addr  out  ADDR_W  to memory.
- mem_we  out  1  to memory.
- mem_wdata  out  DATA_W  to memory.
- mem_rdata  in  DATA_W  from memory; data for the address sampled at edge N is valid after edge N.

Behaviour:
- Reset values, applied immediately on reset assertion:
  - All outputs 0.
  - Internal state cleared: burst_cnt = 0, owner tag = NONE, held instruction = 0.
- Grant each cycle (combinational from current inputs and registered burst_cnt):
  - Loader granted (ld_gnt) if ld_req & (~fetch_req | burst_cnt < MAX_BURST).
  - Otherwise fetch granted (f_gnt) if fetch_req.
  - Otherwise no grant.
- Outputs derived from the grant:
  - ld_ack = ld_gnt.
  - fetch_stall = fetch_req & ~f_gnt.
- Memory drive:
  - On ld_gnt: mem_addr = ld_addr, mem_we = ld_we, mem_wdata = ld_wdata.
  - On f_gnt: mem_addr = fetch_addr, mem_we = 0, mem_wdata = 0.
  - No grant: all three 0.
- burst_cnt update at each edge:
  - ld_gnt & fetch_req: increment, saturating at MAX_BURST.
  - Any other cycle: 0.
  - Effect: a fetch grant or a fetch-idle cycle clears it.
- Owner tag (registered):
  - Set to FETCH on f_gnt, LDREAD on a loader read grant, NONE otherwise.
  - Loader writes return no data.
- Read return, one cycle after the grant:
  - fetch_valid = (owner == FETCH).
  - ld_rvalid = (owner == LDREAD).
  - ld_rdata = mem_rdata when ld_rvalid, else 0.
- fetch_inst:
  - Equals mem_rdata when fetch_valid.
  - Otherwise shows the held register, which captures mem_rdata on every fetch_valid cycle.
  - Effect: the instruction stays stable across stalls.
- load_count increments on each ld_gnt & ld_we and saturates at 2^CNT_W-1.
- Read-after-write: a write granted at edge N followed by a read of the same address granted at edge N+1 returns the new data. Same-cycle collision is impossible because the port is single.
- Requests are level-sensitive:
  - A stalled fetch must hold fetch_req/fetch_addr until granted.
  - The loader must hold ld_* until ld_ack.
  - Deasserting a request early drops it silently.
- Reset mid-burst or mid-read: the pending read return is discarded (no valid pulse), burst_cnt = 0, load_count = 0.

Test Plan:
1. Reset with memory word 0 preloaded to 0x00011821 -> all outputs 0. After release, fetch_req=1 at addr 0 -> fetch_valid=1 and fetch_inst=0x00011821 one cycle later; fetch_stall=0.
2. Fetch only, addr 0,1,2,3 back to back with memory preloaded -> four consecutive fetch_valid pulses with the matching words, one cycle after each address; no stall.
3. Loader only:
   - Write 0xDEADBEEF to addr 5 -> ld_ack=1, mem_we=1, mem_addr=5 in the same cycle; load_count=1.
   - Read addr 5 -> ld_rvalid=1 and ld_rdata=0xDEADBEEF next cycle.
4. Contention, MAX_BURST=4, fetch_req and ld_req held high for 10 cycles -> grant sequence L,L,L,L,F,L,L,L,L,F. fetch_stall=1 on the L cycles, and fetch_inst stays at its prior value until the F return.
5. Write 0x12345678 to addr 0, then fetch addr 0 the next cycle -> fetch_inst=0x12345678. Hold fetch stalled 3 cycles afterwards -> fetch_inst unchanged.
6. Assert reset when burst_cnt=3 with a loader read outstanding -> no ld_rvalid pulse, load_count=0. After release with both requests high, the loader again receives 4 grants before fetch.
